// File: rtl/sr_ff_checker.sv
// Cycle-accurate observer for an SR flip-flop: mirrors the flop in a reference
// model, flags Q mismatches and S=R=1 requests, and keeps saturating counters.
module sr_ff_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dut_rst,
  input  logic             s,
  input  logic             r,
  input  logic             q_obs,
  input  logic             clr,
  output logic             q_exp,
  output logic             tracking,
  output logic             mismatch,
  output logic             invalid,
  output logic             sticky_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] inv_cnt,
  output logic [CNT_W-1:0] chk_cnt
);

  typedef enum logic {
    ST_UNKNOWN = 1'b0,
    ST_TRACK   = 1'b1
  } state_t;

  state_t           r_state,    w_stateNext;
  logic             r_qExp,     w_qExpNext;
  logic             r_mismatch, w_mismatchNext;
  logic             r_invalid,  w_invalidNext;
  logic             r_sticky,   w_stickyNext;
  logic [CNT_W-1:0] r_errCnt,   w_errCntNext;
  logic [CNT_W-1:0] r_invCnt,   w_invCntNext;
  logic [CNT_W-1:0] r_chkCnt,   w_chkCntNext;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_UNKNOWN;
      r_qExp     <= 1'b0;
      r_mismatch <= 1'b0;
      r_invalid  <= 1'b0;
      r_sticky   <= 1'b0;
      r_errCnt   <= '0;
      r_invCnt   <= '0;
      r_chkCnt   <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_qExp     <= w_qExpNext;
      r_mismatch <= w_mismatchNext;
      r_invalid  <= w_invalidNext;
      r_sticky   <= w_stickyNext;
      r_errCnt   <= w_errCntNext;
      r_invCnt   <= w_invCntNext;
      r_chkCnt   <= w_chkCntNext;
    end
  end

  // Compare against the pre-edge model first, then advance the model; clr wins last.
  always_comb begin
    w_stateNext    = r_state;
    w_qExpNext     = r_qExp;
    w_mismatchNext = 1'b0;
    w_invalidNext  = 1'b0;
    w_stickyNext   = r_sticky;
    w_errCntNext   = r_errCnt;
    w_invCntNext   = r_invCnt;
    w_chkCntNext   = r_chkCnt;

    if (en) begin
      if (r_state == ST_TRACK) begin
        w_chkCntNext = satInc(r_chkCnt);
        if (q_obs != r_qExp) begin
          w_mismatchNext = 1'b1;
          w_errCntNext   = satInc(r_errCnt);
          w_stickyNext   = 1'b1;
        end
      end

      // Flop reset dominates, so dut_rst with S=R=1 is a legal request.
      if (dut_rst) begin
        w_qExpNext  = 1'b0;
        w_stateNext = ST_TRACK;
      end else if (s && r) begin
        w_stateNext   = ST_UNKNOWN;
        w_invalidNext = 1'b1;
        w_invCntNext  = satInc(r_invCnt);
      end else if (s) begin
        w_qExpNext  = 1'b1;
        w_stateNext = ST_TRACK;
      end else if (r) begin
        w_qExpNext  = 1'b0;
        w_stateNext = ST_TRACK;
      end
    end

    if (clr) begin
      w_stickyNext = 1'b0;
      w_errCntNext = '0;
      w_invCntNext = '0;
      w_chkCntNext = '0;
    end
  end

  assign q_exp      = r_qExp;
  assign tracking   = (r_state == ST_TRACK);
  assign mismatch   = r_mismatch;
  assign invalid    = r_invalid;
  assign sticky_err = r_sticky;
  assign err_cnt    = r_errCnt;
  assign inv_cnt    = r_invCnt;
  assign chk_cnt    = r_chkCnt;

endmodule

// File: tb/tb_sr_ff_checker.sv
// Directed bench for sr_ff_checker: a default-width and a 2-bit-counter instance
// share one stimulus stream so saturation can be checked alongside normal counting.
module tb_sr_ff_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, en, dutRst, s, r, qObs, clr;

  logic       qExp, trk, mis, inv, sticky;
  logic [7:0] errCnt, invCnt, chkCnt;

  logic       qExpS, trkS, misS, invS, stickyS;
  logic [1:0] errCntS, invCntS, chkCntS;

  int checks   = 0;
  int failures = 0;

  sr_ff_checker #(.CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .en(en), .dut_rst(dutRst), .s(s), .r(r),
    .q_obs(qObs), .clr(clr), .q_exp(qExp), .tracking(trk), .mismatch(mis),
    .invalid(inv), .sticky_err(sticky), .err_cnt(errCnt), .inv_cnt(invCnt),
    .chk_cnt(chkCnt)
  );

  sr_ff_checker #(.CNT_W(2)) u_small (
    .clk(clk), .reset(reset), .en(en), .dut_rst(dutRst), .s(s), .r(r),
    .q_obs(qObs), .clr(clr), .q_exp(qExpS), .tracking(trkS), .mismatch(misS),
    .invalid(invS), .sticky_err(stickyS), .err_cnt(errCntS), .inv_cnt(invCntS),
    .chk_cnt(chkCntS)
  );

  // Single comparison point: counts every check and reports any failure.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one edge's worth of inputs, then settle just after the edge.
  task automatic applyStimulus(input logic iReset, input logic iEn, input logic iDutRst,
                               input logic iS, input logic iR, input logic iQ,
                               input logic iClr);
    reset  = iReset;
    en     = iEn;
    dutRst = iDutRst;
    s      = iS;
    r      = iR;
    qObs   = iQ;
    clr    = iClr;
    @(posedge clk);
    #1;
  endtask

  // Full output check of the default-width instance.
  task automatic checkOutput(input string tag, input logic eQ, input logic eTrk,
                             input logic eMis, input logic eInv, input logic eSticky,
                             input int eErr, input int eInvCnt, input int eChk);
    check({tag, ".q_exp"},      qExp,   eQ);
    check({tag, ".tracking"},   trk,    eTrk);
    check({tag, ".mismatch"},   mis,    eMis);
    check({tag, ".invalid"},    inv,    eInv);
    check({tag, ".sticky_err"}, sticky, eSticky);
    check({tag, ".err_cnt"},    errCnt, eErr);
    check({tag, ".inv_cnt"},    invCnt, eInvCnt);
    check({tag, ".chk_cnt"},    chkCnt, eChk);
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; dutRst = 1'b0; s = 1'b0; r = 1'b0; qObs = 1'b0; clr = 1'b0;

    // Checker reset with random observed-flop activity.
    applyStimulus(0, 1, 0, 1'($urandom), 1'($urandom), 1'($urandom), 0);
    applyStimulus(0, 1, 0, 1'($urandom), 1'($urandom), 1'($urandom), 0);
    checkOutput("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    check("small.reset.err_cnt", errCntS, 0);

    // Correct run: dut_rst, set, reset, hold with q_obs 0,1,0,0.
    applyStimulus(1, 1, 1, 0, 0, 0, 0);
    checkOutput("track.rst", 0, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 0, 0);
    checkOutput("track.set", 1, 1, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 1, 1, 0);
    checkOutput("track.clrq", 0, 1, 0, 0, 0, 0, 0, 2);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    checkOutput("track.hold", 0, 1, 0, 0, 0, 0, 0, 3);

    // Same sequence with q_obs wrong during the hold cycle.
    applyStimulus(1, 1, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 1, 1, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    checkOutput("fault.pre", 0, 1, 0, 0, 0, 0, 0, 7);
    applyStimulus(1, 1, 0, 0, 0, 1, 0);
    checkOutput("fault.hit", 0, 1, 1, 0, 1, 1, 0, 8);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    checkOutput("fault.pulse", 0, 1, 0, 0, 1, 1, 0, 9);
    applyStimulus(1, 1, 0, 0, 0, 0, 1);
    checkOutput("fault.clr", 0, 1, 0, 0, 0, 0, 0, 0);

    // Invalid request while tracking, then unknown holds.
    applyStimulus(1, 1, 0, 1, 1, 0, 0);
    checkOutput("inv.hit", 0, 0, 0, 1, 0, 0, 1, 1);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    checkOutput("inv.pulse", 0, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus(1, 1, 0, 0, 0, 1, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    checkOutput("inv.unknown", 0, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus(1, 1, 0, 1, 0, 1, 0);
    checkOutput("inv.retrack", 1, 1, 0, 0, 0, 0, 1, 1);

    // dut_rst with S=R=1 is not an invalid request.
    applyStimulus(1, 1, 1, 1, 1, 1, 0);
    checkOutput("rstsr", 0, 1, 0, 0, 0, 0, 1, 2);

    // Six tracked cycles with q_obs wrong: small counters saturate at 3.
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 0, 0, 1, 0);
    checkOutput("sat", 0, 1, 1, 0, 1, 6, 1, 8);
    check("small.sat.err_cnt", errCntS, 3);
    check("small.sat.chk_cnt", chkCntS, 3);
    check("small.sat.mismatch", misS, 1);

    // clr on the same edge as a mismatch: counter lost, pulse still fires.
    applyStimulus(1, 1, 0, 0, 0, 1, 1);
    checkOutput("clrmis", 0, 1, 1, 0, 0, 0, 0, 0);
    check("small.clrmis.err_cnt", errCntS, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    checkOutput("clrmis.after", 0, 1, 0, 0, 0, 0, 0, 1);

    // Raise a mismatch pulse, then freeze with en=0 while inputs toggle.
    applyStimulus(1, 1, 0, 0, 0, 1, 0);
    checkOutput("en.pre", 0, 1, 1, 0, 1, 1, 0, 2);
    applyStimulus(1, 0, 0, 1, 0, 1, 0);
    checkOutput("en.off1", 0, 1, 0, 0, 1, 1, 0, 2);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 1, 1, 1, 0);
    checkOutput("en.off3", 0, 1, 0, 0, 1, 1, 0, 2);

    // Mid-run checker reset, then first compare on the second enabled edge.
    applyStimulus(0, 1, 0, 1, 0, 1, 1'b0);
    checkOutput("midreset", 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 1, 0);
    checkOutput("rel.first", 1, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    checkOutput("rel.second", 1, 1, 1, 0, 1, 1, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_ff_checker.md
# sr_ff_checker

Synthesizable observer for the SR flip-flop. It sits beside the flop and watches the flop's own clock, reset, S, R and Q. It keeps a cycle-accurate reference model of the flop and flags every cycle where the observed Q differs from the model. It also flags every S=R=1 (invalid) request and keeps saturating counters for on-chip or bench-side reporting.

## Interface
- CNT_W, default 8: width of every counter.
- clk  input  1  checker clock; the same clock as the observed flop.
- reset  input  1  checker reset; synchronous, active-low.
- en  input  1  observe enable; 0 freezes all state, counters and outputs except pulses, which drop to 0.
- dut_rst  input  1  observed flop's reset; active-high, synchronous.
- s  input  1  observed set request.
- r  input  1  observed reset request.
- q_obs  input  1  observed flop output.
- clr  input  1  synchronous clear of counters and the sticky flag.
- q_exp  output  1  model prediction of q_obs for the current cycle.
- tracking  output  1  1 when the model state is known and comparisons are active.
- mismatch  output  1  one-cycle pulse: q_obs differed from q_exp at the previous edge.
- invalid  output  1  one-cycle pulse: s=r=1 was sampled at the previous edge.
- sticky_err  output  1  set by any mismatch; cleared only by reset or clr.
- err_cnt  output  CNT_W  saturating mismatch count.
- inv_cnt  output  CNT_W  saturating invalid-request count.
- chk_cnt  output  CNT_W  saturating count of comparisons performed.

## Operation
- State machine has two states:
  - UNKNOWN: model undefined, no comparisons.
  - TRACK: q_exp valid. tracking=1 only in TRACK.
- Reset (reset=0 at an edge) sets:
  - state=UNKNOWN, q_exp=0, mismatch=0, invalid=0, sticky_err=0, all counters=0.
  - Reset overrides en, clr and all other inputs.
- Each edge with reset=1 and en=1 does two things in this order, using register values from before the edge.
- Step 1, compare:
  - Runs only if state==TRACK.
  - chk_cnt increments.
  - If q_obs!=q_exp: mismatch=1 next cycle, err_cnt increments, sticky_err=1.
  - Otherwise mismatch=0.
- Step 2, model update, highest priority first:
  - dut_rst=1: q_exp=0, state=TRACK.
  - s=1, r=1: state=UNKNOWN, q_exp holds its value, invalid=1 next cycle, inv_cnt increments.
  - s=1, r=0: q_exp=1, state=TRACK.
  - s=0, r=1: q_exp=0, state=TRACK.
  - s=0, r=0: q_exp and state hold. In UNKNOWN the model stays unknown.
- dut_rst=1 together with s=r=1 is not invalid: no pulse and no inv_cnt change.
- en=0 at an edge:
  - No compare, no update, no counter change.
  - mismatch and invalid go to 0.
- clr=1 at an edge:
  - err_cnt, inv_cnt, chk_cnt and sticky_err go to 0.
  - clr beats a same-edge increment or set; the result is 0 and the event is lost.
  - State, q_exp and the pulses are unaffected.
- Counters stop at 2^CNT_W-1 and never wrap.
- Width rules:
  - All comparisons are 1-bit equality on 0/1 values.
  - X on q_obs is outside scope. The bench detects X with `!==`.

## Timing
- The observed flop updates Q at edge N from s/r/dut_rst sampled at edge N.
- The checker updates q_exp at the same edge N, so q_exp and q_obs are aligned during cycle N→N+1.
- The compare for that cycle happens at edge N+1.
- Latencies:
  - A fault in q_obs during cycle N→N+1 shows on mismatch and err_cnt after edge N+1, one cycle of detection latency.
  - invalid asserts one cycle after the edge at which s=r=1 was sampled.
  - tracking rises the cycle after the first dut_rst or first definite s/r edge.
- A checker reset in the middle of a run discards the model. The first comparison happens no earlier than the second enabled edge after reset is released.
- There are no combinational paths from inputs to outputs. All outputs are registered.

## Test plan
- reset=0 for 2 edges with random s, r, q_obs → q_exp=0, tracking=0, every counter 0, no pulses.
- dut_rst=1 for one edge, then s=1,r=0 / s=0,r=1 / s=0,r=0, with q_obs driven correctly (0,1,0,0) → tracking=1, err_cnt=0, chk_cnt=3 after the fourth edge.
- Same sequence with q_obs forced to 1 in the hold cycle → mismatch is a single pulse one cycle later, err_cnt=1, sticky_err=1. clr=1 then gives err_cnt=0 and sticky_err=0.
- s=r=1 while in TRACK → invalid pulse, inv_cnt=1, tracking=0. Then s=r=0 for 3 edges → chk_cnt unchanged. Then s=1,r=0 → tracking=1.
- CNT_W=2 with q_obs held wrong for 6 tracked cycles → err_cnt stops at 3. clr on the same edge as a mismatch → err_cnt=0 and the mismatch pulse still fires.
- en=0 for 3 edges with toggling s/r → q_exp, state and counters unchanged, pulses 0. Then reset=0 mid-run → all outputs return to their reset values on the next edge.
